// File: rtl/limit_control_multich_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | limit_control_multich_pkg                                            |
// | Float helpers (NaN/zero detect, total-order key) and default limits. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package limit_control_multich_pkg;

   localparam int c_FMAX_W = 64;

   localparam logic [63:0] c_UPPER_DEF_D = 64'h403B_0000_0000_0000;  // 27.0 double
   localparam logic [63:0] c_LOWER_DEF_D = 64'h4000_0000_0000_0000;  //  2.0 double
   localparam logic [63:0] c_UPPER_DEF_S = 64'h0000_0000_41D8_0000;  // 27.0 single
   localparam logic [63:0] c_LOWER_DEF_S = 64'h0000_0000_4000_0000;  //  2.0 single

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_RUN  = 1'b1;

   function automatic logic [63:0] f_width_mask(input int w);
      return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic f_is_zero(input logic [63:0] v, input int w);
      return (v & (f_width_mask(w) >> 1)) == 64'd0;
   endfunction

   function automatic logic f_is_nan(input logic [63:0] v, input int w);
      if (w == 32)
         return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
      return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
   endfunction

   // Unsigned-comparable key; -0 collapses onto +0 first so they compare equal.
   function automatic logic [63:0] f_key(input logic [63:0] v, input int w);
      logic [63:0] n;
      n = f_is_zero(v, w) ? 64'd0 : (v & f_width_mask(w));
      if (n[w-1])
         return ~n & f_width_mask(w);
      return n ^ (64'd1 << (w - 1));
   endfunction

endpackage
`default_nettype wire

// File: rtl/limit_control_multich_float_cmp_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | float_cmp_pipe                                                       |
// | IEEE-754 a>b / a<b compare, registered CMP_LAT stages deep.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module float_cmp_pipe
   import limit_control_multich_pkg::*;
#(
   parameter int W       = 64,
   parameter int CMP_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         agb,
   output logic         alb,
   output logic         a_nan
);

   logic [63:0] w_a64;
   logic [63:0] w_b64;
   logic [63:0] w_ka;
   logic [63:0] w_kb;
   logic [2:0]  w_res;
   logic [2:0]  r_pipe [CMP_LAT];

   always_comb begin
      w_a64 = 64'(a);
      w_b64 = 64'(b);
      w_ka  = f_key(w_a64, W);
      w_kb  = f_key(w_b64, W);
      w_res = {f_is_nan(w_a64, W), (w_ka > w_kb), (w_ka < w_kb)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CMP_LAT; i++)
            r_pipe[i] <= 3'b000;
      end else begin
         r_pipe[0] <= w_res;
         for (int i = 1; i < CMP_LAT; i++)
            r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign a_nan = r_pipe[CMP_LAT-1][2];
   assign agb   = r_pipe[CMP_LAT-1][1];
   assign alb   = r_pipe[CMP_LAT-1][0];

endmodule
`default_nettype wire

// File: rtl/limit_control_multich.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | limit_control_multich                                                |
// | Multi-channel float clamp with programmable limits and frame FSM.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module limit_control_multich
   import limit_control_multich_pkg::*;
#(
   parameter int          W         = 64,
   parameter int          NCH       = 4,
   parameter int          CH_W      = 2,
   parameter int          CMP_LAT   = 1,
   parameter logic [63:0] UPPER_DEF = (W == 32) ? c_UPPER_DEF_S : c_UPPER_DEF_D,
   parameter logic [63:0] LOWER_DEF = (W == 32) ? c_LOWER_DEF_S : c_LOWER_DEF_D
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic [W-1:0]    cfg_upper,
   input  logic [W-1:0]    cfg_lower,
   output logic            cfg_err,
   input  logic            sta,
   input  logic            x_valid,
   input  logic [CH_W-1:0] x_ch,
   input  logic [W-1:0]    x,
   output logic            y_valid,
   output logic [CH_W-1:0] y_ch,
   output logic [W-1:0]    y,
   output logic            sat_hi,
   output logic            sat_lo,
   output logic            done_sig,
   output logic            overrun
);

   localparam int c_CNT_W = CH_W + 1;
   localparam int c_LAST  = CMP_LAT - 1;

   logic [W-1:0]    r_upper [NCH];
   logic [W-1:0]    r_lower [NCH];
   logic            r_cfg_err;
   logic            w_cfg_bad;

   logic            r_vld [CMP_LAT];
   logic [CH_W-1:0] r_ch  [CMP_LAT];
   logic [W-1:0]    r_x   [CMP_LAT];
   logic [W-1:0]    r_lo  [CMP_LAT];
   logic [W-1:0]    r_up  [CMP_LAT];

   logic            w_hi_agb, w_hi_alb, w_hi_nan;
   logic            w_lo_agb, w_lo_alb, w_lo_nan;
   logic            w_unused_cmp;

   logic            r_y_valid;
   logic [CH_W-1:0] r_y_ch;
   logic [W-1:0]    r_y;
   logic            r_sat_hi, r_sat_lo;

   logic [0:0]         r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_overrun;
   logic               w_done;

   always_comb begin
      w_cfg_bad = f_is_nan(64'(cfg_lower), W) || f_is_nan(64'(cfg_upper), W) ||
                  (f_key(64'(cfg_lower), W) > f_key(64'(cfg_upper), W)) ||
                  (int'(cfg_ch) >= NCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cfg_err <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            r_upper[i] <= UPPER_DEF[W-1:0];
            r_lower[i] <= LOWER_DEF[W-1:0];
         end
      end else begin
         r_cfg_err <= cfg_we && w_cfg_bad;
         if (cfg_we && !w_cfg_bad) begin
            r_upper[cfg_ch] <= cfg_upper;
            r_lower[cfg_ch] <= cfg_lower;
         end
      end
   end

   // Limits are sampled here, before any same-cycle config write lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CMP_LAT; i++) begin
            r_vld[i] <= 1'b0;
            r_ch[i]  <= '0;
            r_x[i]   <= '0;
            r_lo[i]  <= '0;
            r_up[i]  <= '0;
         end
      end else begin
         r_vld[0] <= x_valid;
         r_ch[0]  <= x_ch;
         r_x[0]   <= x;
         r_lo[0]  <= r_lower[x_ch];
         r_up[0]  <= r_upper[x_ch];
         for (int i = 1; i < CMP_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_ch[i]  <= r_ch[i-1];
            r_x[i]   <= r_x[i-1];
            r_lo[i]  <= r_lo[i-1];
            r_up[i]  <= r_up[i-1];
         end
      end
   end

   float_cmp_pipe #(.W(W), .CMP_LAT(CMP_LAT)) u_cmp_hi (
      .clk   (clk),
      .rst   (rst),
      .a     (x),
      .b     (r_upper[x_ch]),
      .agb   (w_hi_agb),
      .alb   (w_hi_alb),
      .a_nan (w_hi_nan)
   );

   float_cmp_pipe #(.W(W), .CMP_LAT(CMP_LAT)) u_cmp_lo (
      .clk   (clk),
      .rst   (rst),
      .a     (x),
      .b     (r_lower[x_ch]),
      .agb   (w_lo_agb),
      .alb   (w_lo_alb),
      .a_nan (w_lo_nan)
   );

   assign w_unused_cmp = w_hi_alb ^ w_lo_agb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y_valid <= 1'b0;
         r_y_ch    <= '0;
         r_y       <= '0;
         r_sat_hi  <= 1'b0;
         r_sat_lo  <= 1'b0;
      end else begin
         r_y_valid <= r_vld[c_LAST];
         if (r_vld[c_LAST]) begin
            r_y_ch <= r_ch[c_LAST];
            if (w_hi_nan || w_lo_nan) begin
               r_y      <= r_lo[c_LAST];
               r_sat_hi <= 1'b0;
               r_sat_lo <= 1'b1;
            end else if (w_hi_agb) begin
               r_y      <= r_up[c_LAST];
               r_sat_hi <= 1'b1;
               r_sat_lo <= 1'b0;
            end else if (w_lo_alb) begin
               r_y      <= r_lo[c_LAST];
               r_sat_hi <= 1'b0;
               r_sat_lo <= 1'b1;
            end else begin
               r_y      <= r_x[c_LAST];
               r_sat_hi <= 1'b0;
               r_sat_lo <= 1'b0;
            end
         end
      end
   end

   // done is decoded from registered state so it lines up with the last y_valid.
   assign w_done = (r_state == c_ST_RUN) && r_y_valid &&
                   (r_cnt == c_CNT_W'(NCH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_ST_IDLE;
         r_cnt     <= '0;
         r_overrun <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (sta) begin
                  r_state <= c_ST_RUN;
                  r_cnt   <= '0;
               end
            end
            default: begin
               if (w_done) begin
                  r_cnt   <= '0;
                  r_state <= sta ? c_ST_RUN : c_ST_IDLE;
               end else begin
                  if (r_y_valid)
                     r_cnt <= r_cnt + 1'b1;
                  if (sta)
                     r_overrun <= 1'b1;
               end
            end
         endcase
      end
   end

   assign cfg_err  = r_cfg_err;
   assign y_valid  = r_y_valid;
   assign y_ch     = r_y_ch;
   assign y        = r_y;
   assign sat_hi   = r_sat_hi;
   assign sat_lo   = r_sat_lo;
   assign done_sig = w_done;
   assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_limit_control_multich.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_limit_control_multich                                             |
// | Self-checking bench with a real-arithmetic reference model.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_limit_control_multich;

   localparam int W = 64, NCH = 4, CH_W = 2, CMP_LAT = 1, LAT = CMP_LAT + 1;
   localparam logic [63:0] UP_DEF = 64'h403B000000000000;
   localparam logic [63:0] LO_DEF = 64'h4000000000000000;
   localparam logic [63:0] F30 = 64'h403E000000000000, F10 = 64'h4024000000000000;
   localparam logic [63:0] FM5 = 64'hC014000000000000, F1  = 64'h3FF0000000000000;
   localparam logic [63:0] FNAN = 64'h7FF8000000000000, FM1 = 64'hBFF0000000000000;
   localparam logic [63:0] FHALF = 64'h3FE0000000000000;

   logic clk = 0, rst = 1;
   logic cfg_we = 0, cfg_err, sta = 0, x_valid = 0;
   logic [CH_W-1:0] cfg_ch = '0, x_ch = '0, y_ch;
   logic [W-1:0] cfg_upper = '0, cfg_lower = '0, x = '0, y;
   logic y_valid, sat_hi, sat_lo, done_sig, overrun;

   typedef struct {
      logic [CH_W-1:0] ch;
      logic [63:0]     y;
      logic            hi;
      logic            lo;
      int              t;
   } exp_t;

   exp_t        q[$];
   logic [63:0] m_up [NCH];
   logic [63:0] m_lo [NCH];
   bit          m_exp_err;
   int          n_vec = 0, n_err = 0, cyc = 0;

   limit_control_multich #(.W(W), .NCH(NCH), .CH_W(CH_W), .CMP_LAT(CMP_LAT)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_upper(cfg_upper),
      .cfg_lower(cfg_lower), .cfg_err(cfg_err), .sta(sta), .x_valid(x_valid),
      .x_ch(x_ch), .x(x), .y_valid(y_valid), .y_ch(y_ch), .y(y), .sat_hi(sat_hi),
      .sat_lo(sat_lo), .done_sig(done_sig), .overrun(overrun)
   );

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   function automatic bit is_nan(input logic [63:0] v);
      return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
   endfunction

   function automatic logic [63:0] rnd_val();
      int unsigned k = $urandom_range(0, 9);
      case (k)
         0: return ($urandom_range(0, 1) != 0) ? 64'h7FF8000000000000 : 64'hFFF0000000000001;
         1: return ($urandom_range(0, 1) != 0) ? 64'h8000000000000000 : 64'h0;
         2: return ($urandom_range(0, 1) != 0) ? 64'hFFF0000000000000 : 64'h7FF0000000000000;
         default: return $realtobits(real'(int'($urandom_range(0, 120)) - 60) * 0.5);
      endcase
   endfunction

   task automatic reset_model();
      for (int i = 0; i < NCH; i++) begin
         m_up[i] = UP_DEF;
         m_lo[i] = LO_DEF;
      end
      q.delete();
   endtask

   // Apply one clock of stimulus; the model sees limits as they were before the edge.
   task automatic tick();
      exp_t e;
      bit   wr_ok;
      real  rx, ru, rl;
      if (x_valid) begin
         rx = $bitstoreal(x);
         ru = $bitstoreal(m_up[x_ch]);
         rl = $bitstoreal(m_lo[x_ch]);
         e.ch = x_ch; e.t = cyc;
         if (is_nan(x))     begin e.y = m_lo[x_ch]; e.hi = 0; e.lo = 1; end
         else if (rx > ru)  begin e.y = m_up[x_ch]; e.hi = 1; e.lo = 0; end
         else if (rx < rl)  begin e.y = m_lo[x_ch]; e.hi = 0; e.lo = 1; end
         else               begin e.y = x;          e.hi = 0; e.lo = 0; end
         q.push_back(e);
      end
      wr_ok = cfg_we && !is_nan(cfg_lower) && !is_nan(cfg_upper) &&
              !($bitstoreal(cfg_lower) > $bitstoreal(cfg_upper));
      m_exp_err = cfg_we && !wr_ok;
      @(posedge clk);
      if (wr_ok) begin
         m_up[cfg_ch] = cfg_upper;
         m_lo[cfg_ch] = cfg_lower;
      end
      #1;
      x_valid = 0; cfg_we = 0; sta = 0;
   endtask

   task automatic put_x(input int ch, input logic [63:0] v);
      x_valid = 1; x_ch = CH_W'(ch); x = v;
   endtask

   // Output monitor: result ordering/values/latency and frame behaviour.
   initial begin
      exp_t e;
      bit   in_frame, m_ovr, exp_done;
      int   cnt;
      in_frame = 0; m_ovr = 0; cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_frame = 0; m_ovr = 0; cnt = 0;
            n_vec++;
            if (y_valid !== 1'b0 || done_sig !== 1'b0 || overrun !== 1'b0) begin
               n_err++;
               $display("FAIL reset_outputs y_valid=%b done=%b overrun=%b, required 0 0 0",
                        y_valid, done_sig, overrun);
            end
         end else begin
            exp_done = 0;
            n_vec++;
            if (overrun !== m_ovr) begin
               n_err++;
               $display("FAIL overrun got=%b required=%b t=%0t", overrun, m_ovr, $time);
            end
            if (y_valid === 1'b1) begin
               if (q.size() == 0) begin
                  n_err++;
                  $display("FAIL unexpected_y y_valid=1 with nothing pending t=%0t", $time);
               end else begin
                  e = q.pop_front();
                  n_vec++;
                  if (y_ch !== e.ch || y !== e.y || sat_hi !== e.hi || sat_lo !== e.lo ||
                      (cyc - e.t) != LAT) begin
                     n_err++;
                     $display("FAIL result got ch=%0d y=%h hi=%b lo=%b lat=%0d required ch=%0d y=%h hi=%b lo=%b lat=%0d",
                              y_ch, y, sat_hi, sat_lo, cyc - e.t, e.ch, e.y, e.hi, e.lo, LAT);
                  end
               end
               if (in_frame) begin
                  cnt++;
                  if (cnt == NCH) begin exp_done = 1; in_frame = 0; end
               end
            end
            n_vec++;
            if (done_sig !== exp_done) begin
               n_err++;
               $display("FAIL done_sig got=%b required=%b t=%0t", done_sig, exp_done, $time);
            end
            if (sta) begin
               if (in_frame) m_ovr = 1;
               else begin in_frame = 1; cnt = 0; end
            end
         end
      end
   end

   task automatic test_reset();
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (y !== '0 || y_ch !== '0 || sat_hi !== 0 || sat_lo !== 0 || cfg_err !== 0) begin
         n_err++;
         $display("FAIL reset_state y=%h ch=%0d hi=%b lo=%b err=%b, required all 0",
                  y, y_ch, sat_hi, sat_lo, cfg_err);
      end
      rst = 0;
   endtask

   task automatic test_default_limits();
      put_x(0, F30); tick(); tick();
      n_vec++;
      if (y_valid !== 1 || y !== UP_DEF || sat_hi !== 1 || sat_lo !== 0) begin
         n_err++;
         $display("FAIL clamp_hi got v=%b y=%h hi=%b lo=%b required 1 %h 1 0",
                  y_valid, y, sat_hi, sat_lo, UP_DEF);
      end
      put_x(0, F10); tick(); tick();
      n_vec++;
      if (y_valid !== 1 || y !== F10 || sat_hi !== 0 || sat_lo !== 0) begin
         n_err++;
         $display("FAIL pass_10 got v=%b y=%h hi=%b lo=%b required 1 %h 0 0",
                  y_valid, y, sat_hi, sat_lo, F10);
      end
      tick();
      n_vec++;
      if (y_valid !== 0 || y !== F10) begin
         n_err++;
         $display("FAIL hold got v=%b y=%h required 0 %h", y_valid, y, F10);
      end
   endtask

   task automatic test_below_range();
      logic [63:0] vals [3];
      vals[0] = FM5; vals[1] = F1; vals[2] = FNAN;
      for (int i = 0; i < 3; i++) begin
         put_x(1, vals[i]); tick(); tick();
         n_vec++;
         if (y_valid !== 1 || y !== LO_DEF || sat_lo !== 1 || sat_hi !== 0) begin
            n_err++;
            $display("FAIL clamp_lo[%0d] got v=%b y=%h hi=%b lo=%b required 1 %h 0 1",
                     i, y_valid, y, sat_hi, sat_lo, LO_DEF);
         end
      end
      put_x(1, LO_DEF); tick(); put_x(1, UP_DEF); tick(); tick(); tick();
   endtask

   task automatic test_config();
      cfg_we = 1; cfg_ch = 2; cfg_lower = LO_DEF; cfg_upper = FM1; tick();
      n_vec++;
      if (cfg_err !== 1) begin
         n_err++; $display("FAIL cfg_reject got cfg_err=%b required 1", cfg_err);
      end
      tick();
      n_vec++;
      if (cfg_err !== 0) begin
         n_err++; $display("FAIL cfg_err_pulse got cfg_err=%b required 0", cfg_err);
      end
      put_x(2, F1); tick(); tick();
      n_vec++;
      if (y !== LO_DEF || sat_lo !== 1) begin
         n_err++; $display("FAIL cfg_unchanged got y=%h lo=%b required %h 1", y, sat_lo, LO_DEF);
      end
      cfg_we = 1; cfg_ch = 2; cfg_lower = FM1; cfg_upper = F1; put_x(2, FHALF); tick();
      n_vec++;
      if (cfg_err !== 0) begin
         n_err++; $display("FAIL cfg_accept got cfg_err=%b required 0", cfg_err);
      end
      tick();
      n_vec++;
      if (y !== LO_DEF || sat_lo !== 1 || sat_hi !== 0) begin
         n_err++; $display("FAIL collision got y=%h hi=%b lo=%b required %h 0 1", y, sat_hi, sat_lo, LO_DEF);
      end
      put_x(2, FHALF); tick(); tick();
      n_vec++;
      if (y !== FHALF || sat_lo !== 0 || sat_hi !== 0) begin
         n_err++; $display("FAIL new_limits got y=%h hi=%b lo=%b required %h 0 0", y, sat_hi, sat_lo, FHALF);
      end
      put_x(2, F1); tick(); put_x(2, FM1); tick(); put_x(2, F10); tick(); tick(); tick();
   endtask

   task automatic test_frame();
      sta = 1; tick();
      for (int i = 0; i < NCH; i++) begin put_x(i, rnd_val()); tick(); end
      tick();
      n_vec++;
      if (done_sig !== 1 || y_valid !== 1 || y_ch !== CH_W'(NCH - 1)) begin
         n_err++; $display("FAIL frame_done got done=%b v=%b ch=%0d required 1 1 %0d",
                           done_sig, y_valid, y_ch, NCH - 1);
      end
      tick();
      n_vec++;
      if (done_sig !== 0) begin
         n_err++; $display("FAIL frame_done_pulse got done=%b required 0", done_sig);
      end
   endtask

   task automatic test_back_to_back();
      sta = 1; tick();
      for (int i = 0; i < NCH; i++) begin put_x(i, rnd_val()); tick(); end
      tick();
      sta = 1; tick();
      n_vec++;
      if (overrun !== 0) begin
         n_err++; $display("FAIL sta_on_done got overrun=%b required 0", overrun);
      end
      for (int i = 0; i < NCH; i++) begin put_x(NCH - 1 - i, rnd_val()); tick(); end
      tick();
      n_vec++;
      if (done_sig !== 1 || y_ch !== '0) begin
         n_err++; $display("FAIL restart_done got done=%b ch=%0d required 1 0", done_sig, y_ch);
      end
      tick();
   endtask

   task automatic test_overrun();
      sta = 1; tick();
      put_x(0, rnd_val()); tick();
      put_x(1, rnd_val()); tick();
      sta = 1; put_x(2, rnd_val()); tick();
      n_vec++;
      if (overrun !== 1) begin
         n_err++; $display("FAIL overrun_set got overrun=%b required 1", overrun);
      end
      put_x(3, rnd_val()); tick(); tick();
      n_vec++;
      if (done_sig !== 1) begin
         n_err++; $display("FAIL overrun_done got done=%b required 1", done_sig);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      put_x(0, F30); tick();
      put_x(2, FHALF); tick();
      rst = 1; #1;
      n_vec++;
      if (y_valid !== 0) begin
         n_err++; $display("FAIL reset_drop got y_valid=%b required 0", y_valid);
      end
      reset_model();
      repeat (2) @(posedge clk);
      #1; rst = 0;
      repeat (4) tick();
      put_x(2, FHALF); tick(); tick();
      n_vec++;
      if (y !== LO_DEF || sat_lo !== 1) begin
         n_err++; $display("FAIL reset_limits_lo got y=%h lo=%b required %h 1", y, sat_lo, LO_DEF);
      end
      put_x(0, F30); tick(); tick();
      n_vec++;
      if (y !== UP_DEF || sat_hi !== 1) begin
         n_err++; $display("FAIL reset_limits_hi got y=%h hi=%b required %h 1", y, sat_hi, UP_DEF);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            cfg_we = 1; cfg_ch = CH_W'($urandom_range(0, NCH - 1));
            cfg_lower = rnd_val(); cfg_upper = rnd_val();
         end
         if ($urandom_range(0, 3) != 0) put_x(int'($urandom_range(0, NCH - 1)), rnd_val());
         if ($urandom_range(0, 39) == 0) sta = 1;
         tick();
         n_vec++;
         if (cfg_err !== m_exp_err) begin
            n_err++; $display("FAIL rand_cfg_err got=%b required=%b iter=%0d", cfg_err, m_exp_err, n);
         end
      end
      repeat (LAT + 2) tick();
      n_vec++;
      if (q.size() != 0) begin
         n_err++; $display("FAIL drain got %0d results outstanding required 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_default_limits();
      test_below_range();
      test_config();
      test_frame();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/limit_control_multich.md
Name: limit_control_multich

Overview:
- Time-multiplexed, multi-channel IEEE-754 saturation limiter for the real-time solver datapath; next generation of the single-channel fixed-limit limiter.
- Each accepted sample is clamped to its channel's runtime-programmable [lower, upper] window, with saturation flags.
- Frame sequencing: `sta` opens a frame of NCH samples; `done_sig` pulses after the last result is output.

Parameters:
- W, 64: float width; 64 = double, 32 = single.
- NCH, 4: number of channels (2..16).
- CH_W, 2: channel index width, equal to clog2(NCH).
- CMP_LAT, 1: comparator pipeline stages (1..3).
- UPPER_DEF, 64'h403B000000000000 (27.0): reset upper limit, all channels.
- LOWER_DEF, 64'h4000000000000000 (2.0): reset lower limit, all channels.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  limit write strobe.
- cfg_ch  in  CH_W  channel being configured.
- cfg_upper  in  W  new upper limit.
- cfg_lower  in  W  new lower limit.
- cfg_err  out  1  one-cycle pulse: write rejected.
- sta  in  1  frame start pulse.
- x_valid  in  1  sample strobe.
- x_ch  in  CH_W  sample channel.
- x  in  W  sample.
- y_valid  out  1  result strobe.
- y_ch  out  CH_W  result channel.
- y  out  W  clamped result.
- sat_hi  out  1  y forced to upper limit.
- sat_lo  out  1  y forced to lower limit.
- done_sig  out  1  one-cycle frame-complete pulse.
- overrun  out  1  sticky: sta received while a frame is active; cleared by rst only.

Behaviour:
- Reset values:
  - All outputs 0.
  - Limit registers set to UPPER_DEF / LOWER_DEF.
  - FSM in IDLE; sample counter 0.
- Ordering:
  - Total order over IEEE keys: key = sign ? ~bits : bits ^ MSB; compare keys unsigned.
  - -0 is normalised to +0 before the transform, so -0 == +0.
- Config writes:
  - A write where cfg_lower > cfg_upper, or where either value is NaN (exponent all ones, mantissa != 0), is rejected.
  - On rejection the registers are unchanged and cfg_err pulses 1 cycle later.
  - A valid write updates both limits at the clock edge.
- Write/sample collision: a sample entering on the same cycle as a write to its channel uses the OLD limits. Limits are captured at pipeline entry.
- Pipeline, for each x_valid=1:
  - Stage 0 registers x, x_ch, lower and upper.
  - CMP_LAT comparator stages follow.
  - The output register is loaded last.
  - Latency from x_valid to y_valid is exactly CMP_LAT+1 cycles.
  - Full throughput: one sample per cycle, no stalls, in-order results.
- Clamp priority:
  - x NaN -> y = lower, sat_lo = 1.
  - else x > upper -> y = upper, sat_hi = 1.
  - else x < lower -> y = lower, sat_lo = 1.
  - else y = x, both flags 0.
  - x equal to a limit passes through with no flag.
- Outputs when y_valid = 0: y, y_ch and the flags hold their last values.
- Frame FSM:
  - IDLE: on sta -> RUN, count = 0.
  - RUN: each y_valid increments count. When count reaches NCH -> IDLE and done_sig = 1 for that one cycle, coincident with the last y_valid.
  - sta while in RUN: sets overrun and does not restart the count.
  - sta on the same cycle as the terminating y_valid: treated as a new frame. done_sig pulses and the FSM stays in RUN with count = 0.
- Outside frames: samples accepted while in IDLE are still clamped and output, but are not counted.
- Reset mid-operation: in-flight pipeline contents are discarded, y_valid drops immediately, and the limits revert to their defaults.

Decomposition:
- Shared package: float width constants, NaN/zero detect functions, key transform function, W-dependent default constants.
- One sub-module, float_cmp_pipe:
  - Parameters W, CMP_LAT.
  - Inputs a, b. Outputs agb and alb, registered CMP_LAT stages deep, plus an a_nan flag.
  - Instantiated twice per pipeline: x vs upper, x vs lower.

Test Plan:
- Default limits, ch0:
  - x = 30.0 (0x403E000000000000) -> y = 0x403B000000000000, sat_hi = 1, 2 cycles later (CMP_LAT = 1).
  - x = 10.0 (0x4024000000000000) -> y = x, flags 0.
- Below-range inputs, default limits:
  - x = -5.0 (0xC014000000000000) -> y = 0x4000000000000000, sat_lo = 1.
  - x = 1.0 (0x3FF0000000000000) -> same result.
  - x = NaN (0x7FF8000000000000) -> y = lower, sat_lo = 1.
- Config:
  - Write ch2 lower = 2.0, upper = -1.0 -> cfg_err pulses and ch2 is unchanged.
  - Write ch2 [-1.0, 1.0] while sending ch2 x = 0.5 on the same cycle -> that sample is clamped to 2.0 (old limits).
  - Next ch2 x = 0.5 -> passes as 0.5.
- Frame:
  - sta, then NCH = 4 back-to-back samples on ch0..3 -> four y_valid pulses, done_sig coincident with the 4th.
  - A second sta mid-frame -> overrun = 1 and done_sig still after 4 samples.
- Reset mid-operation:
  - Assert rst with 2 samples in flight -> no y_valid after release; limits read back as defaults (27.0 / 2.0 clamp behaviour).
